// File: rtl/multiboot_pkg.sv
// multiboot_pkg: ICAP command words, SPI mode tables and the ICAP bit-order helper
package multiboot_pkg;
  typedef enum logic [1:0] {SPI_X1 = 2'b00, SPI_X2 = 2'b01, SPI_X4 = 2'b10, SPI_RSVD = 2'b11} spi_mode_t;
  localparam logic [15:0] SYNC1      = 16'hAA99;
  localparam logic [15:0] SYNC2      = 16'h5566;
  localparam logic [15:0] CMD_WR     = 16'h30A1;
  localparam logic [15:0] GEN1_WR    = 16'h3261;
  localparam logic [15:0] GEN2_WR    = 16'h3281;
  localparam logic [15:0] MODE_WR    = 16'h3301;
  localparam logic [15:0] CMD_REBOOT = 16'h000E;
  localparam logic [15:0] NOOP       = 16'h2000;
  localparam logic [15:0] ICAP_NULL  = 16'h0000;
  // Reserved read width falls back to x1
  localparam logic [7:0]  OPC_TAB   [4] = '{8'h03, 8'h3B, 8'h6B, 8'h03};
  localparam logic [15:0] MODEW_TAB [4] = '{16'h2100, 16'h2900, 16'h3100, 16'h2100};
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  function automatic logic [15:0] byte_rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8+i]   = w[15-i];
    end
    return r;
  endfunction
endpackage

// File: rtl/multiboot_slot_ctrl_filter.sv
// reboot_edge_filter: registered trigger on a high followed by FILTER_LEN clean low cycles
module reboot_edge_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic reboot,
  output logic trig
);
  logic [FILTER_LEN:0] sh;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sh   <= '0;
      trig <= 1'b0;
    end else begin
      sh   <= {sh[FILTER_LEN-1:0], reboot};
      trig <= sh[FILTER_LEN] && (sh[FILTER_LEN-1:0] == '0);
    end
  end
endmodule

// File: rtl/multiboot_slot_ctrl.sv
// multiboot_slot_ctrl: writes the ICAP IPROG sequence that reboots into a chosen flash slot
module multiboot_slot_ctrl
  import multiboot_pkg::*;
#(
  parameter int          NUM_SLOTS   = 4,
  parameter logic [23:0] SLOT_BASE   = 24'h000000,
  parameter logic [23:0] SLOT_STRIDE = 24'h098000,
  parameter int          FILTER_LEN  = 3,
  parameter int          USE_PRIM    = 1,
  localparam int         SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reboot,
  input  logic [SLOT_W-1:0] slot,
  input  logic [1:0]        spi_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              icap_ce_n,
  output logic              icap_wr_n,
  output logic [15:0]       icap_i
);
  localparam logic [63:0] LAST_ADDR = 64'(SLOT_BASE) + 64'(NUM_SLOTS - 1) * 64'(SLOT_STRIDE);
  generate
    if (LAST_ADDR >= 64'h100_0000 || NUM_SLOTS < 1 || NUM_SLOTS > 16 || FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_cfg
      $error("multiboot_slot_ctrl: slot map or parameters out of range");
    end
  endgenerate
  logic        trig, bad, last;
  logic [0:0]  state;
  logic [3:0]  idx;
  logic [23:0] addr;
  spi_mode_t   mode;
  logic [15:0] word;
  reboot_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .reboot  (reboot),
    .trig    (trig)
  );
  assign bad  = int'(slot) >= NUM_SLOTS;
  assign word = idx >= 4'd12 ? NOOP :
                idx == 4'd11 ? CMD_REBOOT :
                idx == 4'd10 ? CMD_WR :
                idx == 4'd9  ? MODEW_TAB[mode] :
                idx == 4'd8  ? MODE_WR :
                idx == 4'd7  ? {OPC_TAB[mode], addr[23:16]} :
                idx == 4'd6  ? GEN2_WR :
                idx == 4'd5  ? addr[15:0] :
                idx == 4'd4  ? GEN1_WR :
                idx == 4'd3  ? ICAP_NULL :
                idx == 4'd2  ? CMD_WR :
                idx == 4'd1  ? SYNC2 : SYNC1;
  // busy spans from acceptance until the cycle the bus is released, so it also blocks retriggers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      addr      <= '0;
      mode      <= SPI_X1;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      icap_ce_n <= 1'b1;
      icap_wr_n <= 1'b1;
      icap_i    <= 16'hFFFF;
    end else begin
      done      <= last;
      err       <= trig && !busy && bad;
      last      <= state == ST_RUN && idx == 4'd15;
      icap_ce_n <= state != ST_RUN;
      icap_wr_n <= state != ST_RUN;
      icap_i    <= state == ST_RUN ? byte_rev16(word) : 16'hFFFF;
      if (trig && !busy && !bad) begin
        state <= ST_RUN;
        idx   <= '0;
        addr  <= SLOT_BASE + 24'(slot) * SLOT_STRIDE;
        mode  <= spi_mode_t'(spi_mode);
        busy  <= 1'b1;
      end else begin
        if (last) busy <= 1'b0;
        if (state == ST_RUN) begin
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= ST_IDLE;
        end
      end
    end
  end
  // The primitive exists only in the vendor library, so simulation builds see the ports alone
  generate
    if (USE_PRIM != 0) begin : g_icap
`ifdef SYNTHESIS
      ICAP_SPARTAN6 u_icap (
        .BUSY  (),
        .O     (),
        .CE    (icap_ce_n),
        .CLK   (clock),
        .I     (icap_i),
        .WRITE (icap_wr_n)
      );
`endif
    end
  endgenerate
endmodule

// File: tb/tb_multiboot_slot_ctrl.sv
// tb_multiboot_slot_ctrl: directed and randomized reboot requests checked against a sequence model
module tb_multiboot_slot_ctrl;
  localparam int          NS     = 3;
  localparam int          FL     = 3;
  localparam logic [23:0] BASE   = 24'h000000;
  localparam logic [23:0] STRIDE = 24'h098000;
  logic        clock = 1'b0;
  logic        reset_n, reboot;
  logic [1:0]  slot, spi_mode;
  logic        busy, done, err, icap_ce_n, icap_wr_n;
  logic [15:0] icap_i;
  int tests = 0, fails = 0;
  int cyc, done_cnt, err_cnt, first_busy, first_ce, done_k, err_k;
  logic busy_at_done;
  logic [15:0] cap[$];
  logic [15:0] seq[16];
  multiboot_slot_ctrl #(
    .NUM_SLOTS(NS), .SLOT_BASE(BASE), .SLOT_STRIDE(STRIDE), .FILTER_LEN(FL), .USE_PRIM(0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .reboot(reboot), .slot(slot), .spi_mode(spi_mode),
    .busy(busy), .done(done), .err(err), .icap_ce_n(icap_ce_n), .icap_wr_n(icap_wr_n), .icap_i(icap_i)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] rev(input logic [15:0] w);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[(b / 8) * 8 + (7 - b % 8)] = w[b];
    return r;
  endfunction
  task automatic build_seq(input int s, input int m);
    longint v;
    logic [23:0] a;
    logic [7:0]  opc;
    logic [15:0] mw;
    v   = (longint'(BASE) + longint'(s) * longint'(STRIDE)) % (64'd1 << 24);
    a   = v[23:0];
    opc = m == 1 ? 8'h3B : m == 2 ? 8'h6B : 8'h03;
    mw  = m == 1 ? 16'h2900 : m == 2 ? 16'h3100 : 16'h2100;
    seq = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, a[15:0], 16'h3281, {opc, a[23:16]},
            16'h3301, mw, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
  endtask
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (!icap_ce_n) begin
      cap.push_back(icap_i);
      check("wr_n_with_ce", 32'(icap_wr_n), 32'd0);
    end
    if (done) begin
      done_cnt++;
      if (done_k < 0) begin done_k = cyc; busy_at_done = busy; end
    end
    if (err) begin err_cnt++; if (err_k < 0) err_k = cyc; end
    if (cyc > 0 && busy && first_busy < 0) first_busy = cyc;
    if (cyc > 0 && !icap_ce_n && first_ce < 0) first_ce = cyc;
  endtask
  task automatic run_req(input string tag, input int s, input int m, input int hold, input bit glitch,
                         input int inj_at, input int rst_at, input int exp_n, input bit exp_err);
    cap.delete();
    done_cnt = 0; err_cnt = 0; first_busy = -1; first_ce = -1; done_k = -1; err_k = -1;
    busy_at_done = 1'b1; cyc = -1000;
    build_seq(s, m);
    slot = 2'(s); spi_mode = 2'(m);
    if (glitch) begin
      reboot = 1'b1; tick();
      reboot = 1'b0; repeat (FL - 1) tick();
    end
    reboot = 1'b1; repeat (hold) tick();
    reboot = 1'b0; cyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == inj_at) reboot = 1'b1;
      if (cyc == inj_at + 1) reboot = 1'b0;
      if (cyc == rst_at) reset_n = 1'b0;
      if (cyc == rst_at + 1) begin
        check({tag, "_rst_ce_n"}, 32'(icap_ce_n), 32'd1);
        check({tag, "_rst_icap_i"}, 32'(icap_i), 32'hFFFF);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        reset_n = 1'b1;
      end
    end
    if (exp_err) begin
      check({tag, "_err_count"}, 32'(err_cnt), 32'd1);
      check({tag, "_err_time"}, 32'(err_k), 32'(FL + 2));
      check({tag, "_no_words"}, 32'(cap.size()), 32'd0);
      check({tag, "_never_busy"}, 32'(first_busy), 32'hFFFF_FFFF);
      check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
    end else begin
      check({tag, "_word_count"}, 32'(cap.size()), 32'(exp_n));
      for (int i = 0; i < cap.size() && i < 16; i++)
        check($sformatf("%s_word%0d", tag, i), 32'(cap[i]), 32'(rev(seq[i])));
      check({tag, "_done_count"}, 32'(done_cnt), exp_n == 16 ? 32'd1 : 32'd0);
      check({tag, "_no_err"}, 32'(err_cnt), 32'd0);
      check({tag, "_busy_start"}, 32'(first_busy), 32'(FL + 2));
      check({tag, "_first_word"}, 32'(first_ce), 32'(FL + 3));
      if (exp_n == 16) begin
        check({tag, "_done_time"}, 32'(done_k), 32'(FL + 19));
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      end
    end
  endtask
  initial begin
    reset_n = 1'b0; reboot = 1'b0; slot = '0; spi_mode = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ce_n", 32'(icap_ce_n), 32'd1);
    check("reset_wr_n", 32'(icap_wr_n), 32'd1);
    check("reset_icap_i", 32'(icap_i), 32'hFFFF);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    run_req("slot2_x1", 2, 0, 2, 1'b0, -1, -1, 16, 1'b0);
    run_req("slot1_x4", 1, 2, 1, 1'b0, -1, -1, 16, 1'b0);
    check("sync1_bitrev", 32'(cap[0]), 32'h5599);
    check("slot1_x4_gen1", 32'(cap[5]), 32'(rev(16'h8000)));
    check("slot1_x4_gen2", 32'(cap[7]), 32'(rev(16'h6B09)));
    run_req("slot0_rsvd", 0, 3, 3, 1'b0, -1, -1, 16, 1'b0);
    for (int r = 0; r < 4; r++)
      run_req($sformatf("rand%0d", r), $urandom_range(0, NS - 1), $urandom_range(0, 3),
              $urandom_range(1, 4), 1'b0, -1, -1, 16, 1'b0);
    run_req("glitch", 1, 1, 2, 1'b1, -1, -1, 16, 1'b0);
    run_req("bad_slot", 3, 0, 2, 1'b0, -1, -1, 0, 1'b1);
    run_req("retrigger", 2, 1, 2, 1'b0, FL + 8, -1, 16, 1'b0);
    run_req("mid_reset", 1, 0, 2, 1'b0, -1, FL + 10, 8, 1'b0);
    run_req("after_reset", $urandom_range(0, NS - 1), $urandom_range(0, 2), 2, 1'b0, -1, -1, 16, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
